tree_vote_engine: RTL and testbench

- Parametrised successor to the ensemble voting stage. Collects the per-tree leaf results of N_TREES decision-tree engines and accumulates a per-class score.
- Score mode is selectable per inference: majority (+1 per tree) or weighted (+leaf weight).
- Scans for the arg-max with a defined tie rule, a wait timeout and an invalid-class flag. Sits between the tree engines and the accelerator's result register.

---
 rtl/tree_vote_engine.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_tree_vote_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_vote_engine.sv
// ---------------------------------------------------------------------------
// tree_vote_engine
//
// Ensemble voting stage. Waits for all N_TREES tree engines to report, takes a
// snapshot of their leaf results, and accumulates a per-class score LANES
// trees per cycle. Each tree adds +1 in majority mode or its leaf weight in
// weighted mode. The block then scans the classes for the arg-max, with the
// lowest index winning ties, and presents the result for one done cycle.
//
// Optional build macro: TREE_VOTE_MARGIN_EN
//   Adds the output "margin" (best score minus runner-up score).
//
// Ports:
//   clk          single clock
//   rst          synchronous, active-high reset
//   start        one-cycle request, accepted only while idle (busy=0)
//   mode         0 = majority, 1 = weighted; sampled on the accepted start
//   leaf_class   packed class IDs, tree t at [t*CLASS_W +: CLASS_W]
//   leaf_weight  packed unsigned weights, tree t at [t*WEIGHT_W +: WEIGHT_W]
//   tree_done    per-tree completion levels
//   busy         high while an inference is in flight
//   done         one-cycle pulse when the result outputs are valid
//   prediction   winning class, zero-extended to 8 bits
//   score        winning class score
//   tie          best nonzero score shared by two or more classes
//   invalid      at least one leaf reported a class >= N_CLASSES
//   timeout      inference aborted while waiting for the trees
//   margin       (TREE_VOTE_MARGIN_EN only) best minus runner-up score
// ---------------------------------------------------------------------------
module tree_vote_engine #(
    parameter int N_TREES   = 16,
    parameter int N_CLASSES = 32,
    parameter int CLASS_W   = 8,
    parameter int WEIGHT_W  = 8,
    parameter int LANES     = 4,
    parameter int TIMEOUT   = 0,
    parameter int SCORE_W   = $clog2(N_TREES * (2**WEIGHT_W - 1) + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [N_TREES*CLASS_W-1:0]    leaf_class,
    input  logic [N_TREES*WEIGHT_W-1:0]   leaf_weight,
    input  logic [N_TREES-1:0]            tree_done,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    prediction,
    output logic [SCORE_W-1:0]            score,
    output logic                          tie,
    output logic                          invalid,
    output logic                          timeout
`ifdef TREE_VOTE_MARGIN_EN
    ,
    output logic [SCORE_W-1:0]            margin
`endif
);

    localparam int N_CYC   = N_TREES / LANES;
    localparam int IDX_W   = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int TREE_W  = (N_TREES > 1) ? $clog2(N_TREES) : 1;
    localparam int MAX_A   = (TIMEOUT > N_CLASSES) ? TIMEOUT : N_CLASSES;
    localparam int CNT_MAX = (MAX_A > N_TREES) ? MAX_A : N_TREES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // Control
    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;      // wait cycles / count cycle / scan index
    logic                mode_q, mode_d;

    // Snapshot and per-class scores
    logic [CLASS_W-1:0]  snap_class_q  [N_TREES];
    logic [CLASS_W-1:0]  snap_class_d  [N_TREES];
    logic [WEIGHT_W-1:0] snap_weight_q [N_TREES];
    logic [WEIGHT_W-1:0] snap_weight_d [N_TREES];
    logic [SCORE_W-1:0]  class_score_q [N_CLASSES];
    logic [SCORE_W-1:0]  class_score_d [N_CLASSES];

    // Per-inference accumulators
    logic                inv_acc_q, inv_acc_d;
    logic                to_acc_q, to_acc_d;
    logic [SCORE_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                tie_acc_q, tie_acc_d;
`ifdef TREE_VOTE_MARGIN_EN
    logic [SCORE_W-1:0]  second_q, second_d;
    logic [SCORE_W-1:0]  margin_q, margin_d;
`endif

    // Result registers
    logic                done_q, done_d;
    logic [7:0]          pred_q, pred_d;
    logic [SCORE_W-1:0]  score_out_q, score_out_d;
    logic                tie_q, tie_d;
    logic                invalid_q, invalid_d;
    logic                timeout_q, timeout_d;

    // Lane decode for the current COUNT cycle
    logic [TREE_W-1:0]   lane_tree  [LANES];
    logic [CLASS_W-1:0]  lane_class [LANES];
    logic [SCORE_W-1:0]  lane_inc   [LANES];
    logic [LANES-1:0]    lane_bad;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_tree[gi]  = TREE_W'(cnt_q * CNT_W'(LANES) + CNT_W'(gi));
            assign lane_class[gi] = snap_class_q[lane_tree[gi]];
            assign lane_inc[gi]   = mode_q ? SCORE_W'(snap_weight_q[lane_tree[gi]])
                                           : SCORE_W'(1);
            assign lane_bad[gi]   = 32'(lane_class[gi]) >= N_CLASSES;
        end
    endgenerate

    // Adder tree per class: every lane that names class k contributes, so
    // several lanes voting for the same class in one cycle are all counted.
    logic [SCORE_W-1:0] class_add [N_CLASSES];
    always_comb begin
        for (int k = 0; k < N_CLASSES; k++) begin
            class_add[k] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (!lane_bad[l] && (32'(lane_class[l]) == 32'(k))) begin
                    class_add[k] = class_add[k] + lane_inc[l];
                end
            end
        end
    end

    logic [SCORE_W-1:0] scan_score;
    assign scan_score = class_score_q[IDX_W'(cnt_q)];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        inv_acc_d   = inv_acc_q;
        to_acc_d    = to_acc_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        tie_acc_d   = tie_acc_q;
`ifdef TREE_VOTE_MARGIN_EN
        second_d    = second_q;
        margin_d    = margin_q;
`endif
        done_d      = 1'b0;
        pred_d      = pred_q;
        score_out_d = score_out_q;
        tie_d       = tie_q;
        invalid_d   = invalid_q;
        timeout_d   = timeout_q;
        for (int t = 0; t < N_TREES; t++) begin
            snap_class_d[t]  = snap_class_q[t];
            snap_weight_d[t] = snap_weight_q[t];
        end
        for (int k = 0; k < N_CLASSES; k++) begin
            class_score_d[k] = class_score_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WAIT;
                    mode_d     = mode;
                    cnt_d      = '0;
                    inv_acc_d  = 1'b0;
                    to_acc_d   = 1'b0;
                    best_d     = '0;
                    best_idx_d = '0;
                    tie_acc_d  = 1'b0;
`ifdef TREE_VOTE_MARGIN_EN
                    second_d   = '0;
`endif
                    tie_d      = 1'b0;
                    invalid_d  = 1'b0;
                    timeout_d  = 1'b0;
                end
            end

            S_WAIT: begin
                if (&tree_done) begin
                    for (int t = 0; t < N_TREES; t++) begin
                        snap_class_d[t]  = leaf_class[t*CLASS_W +: CLASS_W];
                        snap_weight_d[t] = leaf_weight[t*WEIGHT_W +: WEIGHT_W];
                    end
                    for (int k = 0; k < N_CLASSES; k++) begin
                        class_score_d[k] = '0;
                    end
                    cnt_d   = '0;
                    state_d = S_COUNT;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                    // Accumulators were cleared on start, so OUT publishes zeros.
                    to_acc_d = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_COUNT: begin
                for (int k = 0; k < N_CLASSES; k++) begin
                    class_score_d[k] = class_score_q[k] + class_add[k];
                end
                inv_acc_d = inv_acc_q | (|lane_bad);
                if (cnt_q == CNT_W'(N_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SCAN: begin
                // Strictly-greater replacement keeps the lowest index on ties.
                if (scan_score > best_q) begin
                    best_d     = scan_score;
                    best_idx_d = IDX_W'(cnt_q);
                    tie_acc_d  = 1'b0;
`ifdef TREE_VOTE_MARGIN_EN
                    second_d   = best_q;
`endif
                end else if ((scan_score == best_q) && (scan_score != '0)) begin
                    tie_acc_d  = 1'b1;
`ifdef TREE_VOTE_MARGIN_EN
                    second_d   = scan_score;
`endif
                end
`ifdef TREE_VOTE_MARGIN_EN
                else if (scan_score > second_q) begin
                    second_d   = scan_score;
                end
`endif
                if (cnt_q == CNT_W'(N_CLASSES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_OUT: begin
                pred_d      = 8'(best_idx_q);
                score_out_d = best_q;
                tie_d       = tie_acc_q;
                invalid_d   = inv_acc_q;
                timeout_d   = to_acc_q;
`ifdef TREE_VOTE_MARGIN_EN
                margin_d    = best_q - second_q;
`endif
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            inv_acc_q   <= 1'b0;
            to_acc_q    <= 1'b0;
            best_q      <= '0;
            best_idx_q  <= '0;
            tie_acc_q   <= 1'b0;
`ifdef TREE_VOTE_MARGIN_EN
            second_q    <= '0;
            margin_q    <= '0;
`endif
            done_q      <= 1'b0;
            pred_q      <= '0;
            score_out_q <= '0;
            tie_q       <= 1'b0;
            invalid_q   <= 1'b0;
            timeout_q   <= 1'b0;
            for (int t = 0; t < N_TREES; t++) begin
                snap_class_q[t]  <= '0;
                snap_weight_q[t] <= '0;
            end
            for (int k = 0; k < N_CLASSES; k++) begin
                class_score_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            inv_acc_q   <= inv_acc_d;
            to_acc_q    <= to_acc_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            tie_acc_q   <= tie_acc_d;
`ifdef TREE_VOTE_MARGIN_EN
            second_q    <= second_d;
            margin_q    <= margin_d;
`endif
            done_q      <= done_d;
            pred_q      <= pred_d;
            score_out_q <= score_out_d;
            tie_q       <= tie_d;
            invalid_q   <= invalid_d;
            timeout_q   <= timeout_d;
            for (int t = 0; t < N_TREES; t++) begin
                snap_class_q[t]  <= snap_class_d[t];
                snap_weight_q[t] <= snap_weight_d[t];
            end
            for (int k = 0; k < N_CLASSES; k++) begin
                class_score_q[k] <= class_score_d[k];
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign prediction = pred_q;
    assign score      = score_out_q;
    assign tie        = tie_q;
    assign invalid    = invalid_q;
    assign timeout    = timeout_q;
`ifdef TREE_VOTE_MARGIN_EN
    assign margin     = margin_q;
`endif

endmodule

// File: tb/tb_tree_vote_engine.sv
// ---------------------------------------------------------------------------
// tb_tree_vote_engine
//
// Directed vectors for tree_vote_engine (16 trees, 4 lanes, 8 classes,
// wait timeout of 20 cycles). The driver pushes the hand-computed result of
// each inference into a scoreboard queue; a monitor pops and compares every
// time the DUT raises done, including the done-to-start latency.
// ---------------------------------------------------------------------------
module tb_tree_vote_engine;

    localparam int NT  = 16;
    localparam int NC  = 8;
    localparam int CW  = 8;
    localparam int WW  = 8;
    localparam int LN  = 4;
    localparam int TO  = 20;
    localparam int SW  = $clog2(NT * (2**WW - 1) + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [NT*CW-1:0]  leaf_class;
    logic [NT*WW-1:0]  leaf_weight;
    logic [NT-1:0]     tree_done;
    logic              busy;
    logic              done;
    logic [7:0]        prediction;
    logic [SW-1:0]     score;
    logic              tie;
    logic              invalid;
    logic              timeout;
`ifdef TREE_VOTE_MARGIN_EN
    logic [SW-1:0]     margin;
`endif

    tree_vote_engine #(
        .N_TREES   (NT),
        .N_CLASSES (NC),
        .CLASS_W   (CW),
        .WEIGHT_W  (WW),
        .LANES     (LN),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .leaf_class  (leaf_class),
        .leaf_weight (leaf_weight),
        .tree_done   (tree_done),
        .busy        (busy),
        .done        (done),
        .prediction  (prediction),
        .score       (score),
        .tie         (tie),
        .invalid     (invalid),
        .timeout     (timeout)
`ifdef TREE_VOTE_MARGIN_EN
        ,
        .margin      (margin)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    done_cyc;
        int    pred;
        int    scr;
        int    tie;
        int    inv;
        int    to;
        int    mrg;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".latency"},    cyc, e.done_cyc);
                check({e.name, ".prediction"}, int'(prediction), e.pred);
                check({e.name, ".score"},      int'(score), e.scr);
                check({e.name, ".tie"},        int'(tie), e.tie);
                check({e.name, ".invalid"},    int'(invalid), e.inv);
                check({e.name, ".timeout"},    int'(timeout), e.to);
                check({e.name, ".busy"},       int'(busy), 0);
`ifdef TREE_VOTE_MARGIN_EN
                check({e.name, ".margin"},     int'(margin), e.mrg);
`endif
                $display("txn %s: pred=%0d score=%0d tie=%0b inv=%0b to=%0b at cycle %0d",
                         e.name, prediction, score, tie, invalid, timeout, cyc);
            end
        end
    end

    task automatic set_leaf(input int t, input int c, input int w);
        leaf_class[t*CW +: CW]  = CW'(c);
        leaf_weight[t*WW +: WW] = WW'(w);
    endtask

    // Called just after a posedge; start is sampled on the following edge.
    task automatic issue(input string name, input logic m, input bit push,
                         input int lat, input int p, input int s,
                         input int ti, input int iv, input int tt, input int mg);
        exp_t e;
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.name = name; e.done_cyc = cyc + lat; e.pred = p; e.scr = s;
            e.tie = ti; e.inv = iv; e.to = tt; e.mrg = mg;
            sb.push_back(e);
        end
    endtask

    // Returns just after the edge that raised done (i.e. inside the done cycle).
    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s.wait: got no done expected done within %0d cycles", name, limit);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        leaf_class = '0; leaf_weight = '0; tree_done = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.prediction", int'(prediction), 0);
        check("reset.score", int'(score), 0);
        check("reset.tie", int'(tie), 0);
        check("reset.invalid", int'(invalid), 0);
        check("reset.timeout", int'(timeout), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10 trees class 3, 6 trees class 5
        for (int t = 0; t < NT; t++) set_leaf(t, (t < 10) ? 3 : 5, 99);
        issue("maj_3x10", 1'b0, 1'b1, 14, 3, 10, 0, 0, 0, 4);
        check("maj_3x10.busy_after_start", int'(busy), 1);
        wait_done("maj_3x10", 40);

        // 8/8 split: lowest index wins, tie flagged; extra start mid-run ignored
        for (int t = 0; t < NT; t++) set_leaf(t, (t < 8) ? 2 : 6, 7);
        issue("maj_tie", 1'b0, 1'b1, 14, 2, 8, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("maj_tie", 40);

        // Weighted: 15 x class 1 weight 1, one class 4 weight 200 (start in done cycle)
        for (int t = 0; t < NT; t++) set_leaf(t, (t < 15) ? 1 : 4, (t < 15) ? 1 : 200);
        issue("wgt_200", 1'b1, 1'b1, 14, 4, 200, 0, 0, 0, 185);
        wait_done("wgt_200", 40);

        // Four lanes of one cycle all class 7; other classes 3 votes each
        for (int t = 0; t < NT; t++) set_leaf(t, (t < 4) ? 7 : (t - 4) / 3, 0);
        issue("lane_collide", 1'b0, 1'b1, 14, 7, 4, 0, 0, 0, 1);
        wait_done("lane_collide", 40);

        // One out-of-range class
        for (int t = 0; t < NT; t++) set_leaf(t, (t == 9) ? 40 : 0, 5);
        issue("invalid_cls", 1'b0, 1'b1, 14, 0, 15, 0, 1, 0, 15);
        wait_done("invalid_cls", 40);

        // Weighted collision in one cycle: 10+20+30+40 on class 5, 12 x 1 on class 2
        for (int t = 0; t < NT; t++) set_leaf(t, (t < 4) ? 5 : 2, (t < 4) ? (t + 1) * 10 : 1);
        issue("wgt_collide", 1'b1, 1'b1, 14, 5, 100, 0, 0, 0, 88);
        wait_done("wgt_collide", 40);

        // All weights zero: every score zero
        for (int t = 0; t < NT; t++) set_leaf(t, 3, 0);
        issue("all_zero", 1'b1, 1'b1, 14, 0, 0, 0, 0, 0, 0);
        wait_done("all_zero", 40);

        // Tree 5 never finishes: timeout after 20 wait cycles
        tree_done = '1;
        tree_done[5] = 1'b0;
        issue("timeout", 1'b0, 1'b1, 22, 0, 0, 0, 0, 1, 0);
        wait_done("timeout", 60);
        tree_done = '1;

        // Reset in the middle of COUNT: no done, outputs cleared
        for (int t = 0; t < NT; t++) set_leaf(t, 6, 1);
        issue("reset_mid", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_mid.busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_mid.busy", int'(busy), 0);
        check("reset_mid.prediction", int'(prediction), 0);
        check("reset_mid.score", int'(score), 0);
        check("reset_mid.timeout", int'(timeout), 0);
        check("reset_mid.tie", int'(tie), 0);
        check("reset_mid.invalid", int'(invalid), 0);
        repeat (30) @(posedge clk);
        #1;

        // Recovery run after reset: all 16 votes on class 6
        issue("after_reset", 1'b0, 1'b1, 14, 6, 16, 0, 0, 0, 16);
        wait_done("after_reset", 40);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
